apb_pwm_regs: RTL and testbench
===============================

// Module: apb_pwm_regs
// PURPOSE
//  APB3 slave register bank directly upstream of the PWM generator; drives its period/pulse/size/enable.
//  Software writes staging registers; staged values are copied to the active outputs together, at a PWM period boundary.
//  This gives glitch-free reconfiguration. A status register exposes pending-commit state.
// PARAMETERS
//  ADDR_WIDTH   12   PADDR width; only PADDR[4:2] decoded, upper bits must be 0 (else PSLVERR)
//  WAIT_STATES  0    ACCESS-phase wait cycles inserted before PREADY (0..7)
//  RST_PERIOD   255  reset value of staging and active period
// PORTS
//  PCLK        in   1           APB clock; the only clock
//  PRESET      in   1           asynchronous, active-high reset
//  PSEL        in   1           APB select
//  PENABLE     in   1           APB access phase
//  PWRITE      in   1           1=write, 0=read
//  PADDR       in   ADDR_WIDTH  byte address
//  PWDATA      in   32          write data
//  PRDATA      out  32          read data, valid when PREADY=1
//  PREADY      out  1           transfer complete
//  PSLVERR     out  1           error, valid when PREADY=1
//  period_end  in   1           one-cycle pulse from PWM block when its counter wraps
//  period      out  32          active period to PWM
//  pulse       out  32          active pulse to PWM
//  size        out  32          active size to PWM
//  enable      out  32          active enable to PWM (bit0 = run)
// BEHAVIOUR
//  Reset: PRDATA=0, PREADY=0, PSLVERR=0, period=staging period=RST_PERIOD, all other regs/outputs=0, pending=0, FSM=IDLE.
//  Register map (word offsets):
//   0x00 PERIOD (RW, staged); 0x04 PULSE (RW, staged); 0x08 SIZE (RW, staged, bits[31:8] read 0)
//   0x0C ENABLE (RW, immediate: write updates enable output next cycle, no staging)
//   0x10 STATUS (RO: bit0=pending, bit1=enable[0]); 0x14 ID (RO, 32'h5057_4D01)
//  APB FSM: IDLE -> (PSEL & !PENABLE) SETUP -> ACCESS; ACCESS counts WAIT_STATES cycles with PREADY=0.
//   Then PREADY=1 for exactly one cycle -> IDLE; back-to-back SETUP allowed straight from that cycle.
//  Writes/reads take effect only in the PREADY=1 cycle; PRDATA registered, valid only then, else 0.
//  PSLVERR=1 (with PREADY) for: PADDR[1:0]!=0, unmapped offset, upper address bits set, write to STATUS/ID.
//   On error: no register changes; read returns 0.
//  PENABLE deasserted or PSEL dropped mid-ACCESS: FSM aborts to IDLE, no side effects.
//  Any write to PERIOD/PULSE/SIZE sets pending=1.
//  Commit (all three active <= staging in one cycle, pending<=0) when pending & (period_end | !enable[0]).
//  Simultaneous staged write completion and commit cycle: commit copies pre-write staging; pending stays 1.
//  The new value then commits at the next boundary.
//  Write of ENABLE bit0 1->0 while pending: commit occurs the following cycle (since !enable[0]).
//  Widths: all registers 32-bit, no arithmetic; SIZE masked to [7:0] on write.
//  Reset mid-transfer: everything to reset values immediately (async), transfer lost.
// STRUCTURE
//  Package apb_pwm_regs_pkg: offset localparams (OFS_PERIOD..OFS_ID), ID_VALUE, typedef enum {IDLE,SETUP,ACCESS} apb_state_t.
//  Sub-module apb_slave_fsm: APB handshake + wait counter; outputs wr_strobe/rd_strobe/addr_ok.
//  Register bank, staging/active copies and commit logic live in apb_pwm_regs.
// TESTING
//  Reset -> read PERIOD=255, PULSE=0, ENABLE=0; period output=255, PREADY idle 0.
//  WAIT_STATES=2, write PULSE=100 -> PREADY high on 3rd ACCESS cycle; STATUS=1; pulse output still 0.
//  enable[0]=1, write PERIOD=10/PULSE=5/SIZE=0x1FF, pulse period_end -> next cycle outputs 10/5/0xFF, STATUS bit0=0.
//  enable[0]=0, write PULSE=7 -> pulse output=7 two cycles after PREADY, no period_end needed.
//  Write PULSE=9 in same cycle as period_end (pending from prior write of 3) -> pulse=3, pending=1; next period_end -> 9.
//  Read 0x18, write 0x14, PADDR=0x02 -> PSLVERR=1 each, PRDATA=0, no register changes.
//  Assert PRESET during ACCESS with PERIOD write -> all outputs reset, PERIOD reads 255 afterwards.

Source files
------------

// File: rtl/apb_pwm_regs_pkg.sv
// Shared constants and types for the APB PWM register bank: byte offsets,
// ID value, APB slave FSM state encoding and the address legality check.
package apb_pwm_regs_pkg;

  localparam logic [4:0] OFS_PERIOD = 5'h00;
  localparam logic [4:0] OFS_PULSE  = 5'h04;
  localparam logic [4:0] OFS_SIZE   = 5'h08;
  localparam logic [4:0] OFS_ENABLE = 5'h0C;
  localparam logic [4:0] OFS_STATUS = 5'h10;
  localparam logic [4:0] OFS_ID     = 5'h14;

  localparam logic [31:0] ID_VALUE = 32'h5057_4D01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Low five address bits must hit a mapped word; STATUS and ID are read-only.
  function automatic logic ofs_ok(input logic [4:0] ofs, input logic wr);
    case (ofs)
      OFS_PERIOD, OFS_PULSE, OFS_SIZE, OFS_ENABLE: ofs_ok = 1'b1;
      OFS_STATUS, OFS_ID:                          ofs_ok = !wr;
      default:                                     ofs_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 slave handshake: IDLE/SETUP/ACCESS tracking, wait-state counter,
// registered PREADY/PSLVERR and the strobes the register bank acts on.
module apb_slave_fsm
  import apb_pwm_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  wr_strobe_o,
  output logic                  rd_strobe_o,
  output logic                  addr_ok_o,
  output apb_state_t            state_o
);

  // Handshake: a transfer completes in the single cycle PREADY=1; the
  // register bank commits writes in that cycle, and read data is captured
  // on the edge that raises PREADY so it is valid alongside it.
  apb_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pready_q, pslverr_q;
  logic       ready_d;
  logic       sel_access;

  assign sel_access = PSEL && PENABLE;
  assign addr_ok_o  = (PADDR[ADDR_WIDTH-1:5] == '0) && ofs_ok(PADDR[4:0], PWRITE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (sel_access) begin
          state_d = ACCESS;
          cnt_d   = 3'd0;
          ready_d = (WAIT_STATES == 0);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
        end else if (sel_access) begin
          cnt_d   = cnt_q + 3'd1;
          ready_d = (cnt_d == 3'(WAIT_STATES));
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= ready_d;
      pslverr_q <= ready_d && !addr_ok_o;
    end
  end

  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign wr_strobe_o = pready_q && !pslverr_q && PWRITE;
  assign rd_strobe_o = ready_d && addr_ok_o && !PWRITE;
  assign state_o     = state_q;

endmodule

// File: rtl/apb_pwm_regs.sv
// APB register bank feeding the PWM generator. PERIOD/PULSE/SIZE are staged
// and copied to the active outputs together at a period boundary.
module apb_pwm_regs
  import apb_pwm_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RST_PERIOD  = 32'd255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  period_end,
  output logic [31:0]           period,
  output logic [31:0]           pulse,
  output logic [31:0]           size,
  output logic [31:0]           enable
);

  logic       wr_strobe, rd_strobe, addr_ok, wr_en;
  apb_state_t fsm_state;

  logic [31:0] stg_period_q, stg_pulse_q, stg_size_q;
  logic [31:0] period_q, pulse_q, size_q, enable_q;
  logic [31:0] prdata_q, rdata;
  logic        pending_q, commit, wr_staged;

  apb_slave_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .pready_o   (PREADY),
    .pslverr_o  (PSLVERR),
    .wr_strobe_o(wr_strobe),
    .rd_strobe_o(rd_strobe),
    .addr_ok_o  (addr_ok),
    .state_o    (fsm_state)
  );

  assign wr_en     = wr_strobe && (fsm_state == ACCESS);
  assign wr_staged = wr_en && ((PADDR[4:0] == OFS_PERIOD) || (PADDR[4:0] == OFS_PULSE) ||
                               (PADDR[4:0] == OFS_SIZE));
  // Non-blocking copy takes the pre-write staging value when a write lands on the commit edge.
  assign commit    = pending_q && (period_end || !enable_q[0]);

  always_comb begin
    rdata = 32'd0;
    case (PADDR[4:0])
      OFS_PERIOD: rdata = stg_period_q;
      OFS_PULSE:  rdata = stg_pulse_q;
      OFS_SIZE:   rdata = stg_size_q;
      OFS_ENABLE: rdata = enable_q;
      OFS_STATUS: rdata = {30'd0, enable_q[0], pending_q};
      OFS_ID:     rdata = ID_VALUE;
      default:    rdata = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      stg_period_q <= RST_PERIOD;
      stg_pulse_q  <= 32'd0;
      stg_size_q   <= 32'd0;
      period_q     <= RST_PERIOD;
      pulse_q      <= 32'd0;
      size_q       <= 32'd0;
      enable_q     <= 32'd0;
      pending_q    <= 1'b0;
      prdata_q     <= 32'd0;
    end else begin
      prdata_q <= (rd_strobe && addr_ok) ? rdata : 32'd0;
      if (wr_en && PADDR[4:0] == OFS_PERIOD) stg_period_q <= PWDATA;
      if (wr_en && PADDR[4:0] == OFS_PULSE)  stg_pulse_q  <= PWDATA;
      if (wr_en && PADDR[4:0] == OFS_SIZE)   stg_size_q   <= {24'd0, PWDATA[7:0]};
      if (wr_en && PADDR[4:0] == OFS_ENABLE) enable_q     <= PWDATA;
      if (commit) begin
        period_q <= stg_period_q;
        pulse_q  <= stg_pulse_q;
        size_q   <= stg_size_q;
      end
      if (wr_staged)   pending_q <= 1'b1;
      else if (commit) pending_q <= 1'b0;
    end
  end

  assign PRDATA = prdata_q;
  assign period = period_q;
  assign pulse  = pulse_q;
  assign size   = size_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_apb_pwm_regs.sv
// Directed bench for apb_pwm_regs with two APB wait states: register access,
// staged commit at period boundaries, error responses, abort and async reset.
module tb_apb_pwm_regs;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, period_end;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA, period, pulse, size, enable;
  logic        PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_pwm_regs #(
    .ADDR_WIDTH (12),
    .WAIT_STATES(2),
    .RST_PERIOD (32'd255)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .period_end(period_end),
    .period    (period),
    .pulse     (pulse),
    .size      (size),
    .enable    (enable)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one APB transfer; pe raises period_end during the completion cycle
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic pe, output logic [31:0] rd, output logic err, output int n);
    logic got;
    got = 1'b0; rd = '0; err = 1'b0; n = 0;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    while (!got && n < 20) begin
      @(negedge PCLK);
      n++;
      if (PREADY) begin
        got = 1'b1; rd = PRDATA; err = PSLVERR; period_end = pe;
      end
    end
    if (!got) begin
      total++; bad++;
      $error("FAIL apb_timeout: observed=no PREADY expected=PREADY within 20 cycles");
    end
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; period_end = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [11:0] addr, input logic [31:0] data,
                        input logic pe);
    logic [31:0] rd; logic err; int n;
    apb(1'b1, addr, data, pe, rd, err, n);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_lat"}, n, 32'd3);
  endtask

  task automatic rd_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err; int n;
    apb(1'b0, addr, 32'd0, 1'b0, rd, err, n);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check(tag, rd, exp);
  endtask

  task automatic err_xfer(input string tag, input logic wr, input logic [11:0] addr);
    logic [31:0] rd; logic err; int n;
    apb(wr, addr, 32'hDEAD_BEEF, 1'b0, rd, err, n);
    check({tag, "_slverr"}, {31'd0, err}, 32'd1);
    check({tag, "_prdata"}, rd, 32'd0);
  endtask

  task automatic pulse_period_end();
    @(negedge PCLK); period_end = 1'b1;
    @(negedge PCLK); period_end = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; period_end = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;

    // reset state
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_period", period, 32'd255);
    check("rst_pulse", pulse, 32'd0);
    check("rst_size", size, 32'd0);
    check("rst_enable", enable, 32'd0);
    rd_reg("rd_period_rst", 12'h000, 32'd255);
    rd_reg("rd_pulse_rst", 12'h004, 32'd0);
    rd_reg("rd_enable_rst", 12'h00C, 32'd0);
    rd_reg("rd_id", 12'h014, 32'h5057_4D01);

    // enable running, then stage PULSE: latency three ACCESS cycles, no commit yet
    wr_reg("wr_enable1", 12'h00C, 32'd1, 1'b0);
    check("enable_out1", enable, 32'd1);
    wr_reg("wr_pulse100", 12'h004, 32'd100, 1'b0);
    check("pulse_hold0", pulse, 32'd0);
    rd_reg("status_pend", 12'h010, 32'd3);

    // stage full set, commit on period_end
    wr_reg("wr_period10", 12'h000, 32'd10, 1'b0);
    wr_reg("wr_pulse5", 12'h004, 32'd5, 1'b0);
    wr_reg("wr_size1ff", 12'h008, 32'h1FF, 1'b0);
    rd_reg("rd_size_mask", 12'h008, 32'hFF);
    check("period_pre", period, 32'd255);
    pulse_period_end();
    check("period_commit", period, 32'd10);
    check("pulse_commit", pulse, 32'd5);
    check("size_commit", size, 32'hFF);
    rd_reg("status_clear", 12'h010, 32'd2);

    // staged write lands on the commit edge: old staging commits, pending stays
    wr_reg("wr_pulse3", 12'h004, 32'd3, 1'b0);
    wr_reg("wr_pulse9_pe", 12'h004, 32'd9, 1'b1);
    check("pulse_race", pulse, 32'd3);
    rd_reg("status_race", 12'h010, 32'd3);
    rd_reg("rd_pulse9", 12'h004, 32'd9);
    pulse_period_end();
    check("pulse_next", pulse, 32'd9);

    // enable 1->0 while pending commits the following cycle
    wr_reg("wr_pulse20", 12'h004, 32'd20, 1'b0);
    wr_reg("wr_enable0", 12'h00C, 32'd0, 1'b0);
    check("enable_out0", enable, 32'd0);
    check("pulse_before_dis", pulse, 32'd9);
    @(negedge PCLK);
    check("pulse_dis_commit", pulse, 32'd20);

    // disabled: commit two cycles after PREADY without period_end
    wr_reg("wr_pulse7", 12'h004, 32'd7, 1'b0);
    check("pulse_imm_wait", pulse, 32'd20);
    @(negedge PCLK);
    check("pulse_imm", pulse, 32'd7);

    // error responses leave registers untouched
    err_xfer("rd_unmapped", 1'b0, 12'h018);
    err_xfer("wr_id", 1'b1, 12'h014);
    err_xfer("wr_status", 1'b1, 12'h010);
    err_xfer("wr_misalign", 1'b1, 12'h002);
    err_xfer("rd_upper", 1'b0, 12'h100);
    rd_reg("rd_period_kept", 12'h000, 32'd10);
    rd_reg("rd_pulse_kept", 12'h004, 32'd7);

    // abort mid-ACCESS: no completion, no side effects
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'd77;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      check("abort_pready", {31'd0, PREADY}, 32'd0);
    end
    rd_reg("rd_period_abort", 12'h000, 32'd10);
    rd_reg("status_abort", 12'h010, 32'd0);

    // async reset during a PERIOD write
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h33;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("period_before_rst", period, 32'd10);
    PRESET = 1'b1;
    #1;
    check("mid_rst_period", period, 32'd255);
    check("mid_rst_pulse", pulse, 32'd0);
    check("mid_rst_size", size, 32'd0);
    check("mid_rst_pready", {31'd0, PREADY}, 32'd0);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    rd_reg("rd_period_post_rst", 12'h000, 32'd255);
    rd_reg("rd_pulse_post_rst", 12'h004, 32'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
